// File: rtl/core2axi_lite_pipe.sv
// rtl/core2axi_lite_pipe.sv - pipelined core data port to AXI4-Lite master bridge
// Single issue slot feeds AW/W or AR; an order FIFO serialises B/R completions back to the core.
module core2axi_lite_pipe #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  output logic                        data_err_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                        data_we_i,
  input  logic [3:0]                  data_be_i,
  input  logic [31:0]                 data_wdata_i,
  output logic [31:0]                 data_rdata_o,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  input  logic [1:0]                  b_resp_i,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i,
  input  logic                        r_valid_i,
  output logic                        r_ready_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam bit IS64 = (AXI_DATA_WIDTH == 64);

  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]                be_q, be_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      aw_pend_q, aw_pend_d;
  logic                      w_pend_q, w_pend_d;
  logic                      ar_pend_q, ar_pend_d;

  logic                      fifo_we_q [MAX_OUTSTANDING];
  logic                      fifo_a2_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic [31:0]               rdata_q, rdata_d;

  logic        slot_empty, gnt, fifo_empty, head_we, head_a2;
  logic        b_hs, r_hs, pop;
  logic [1:0]  pop_resp;
  logic [63:0] r_ext;
  logic [31:0] rd_lane;

  assign slot_empty = !(aw_pend_q || w_pend_q || ar_pend_q);
  assign gnt        = data_req_i && !rst_i && slot_empty && (cnt_q < MAX_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign head_we    = fifo_we_q[rd_ptr_q];
  assign head_a2    = fifo_a2_q[rd_ptr_q];

  assign b_ready_o = !fifo_empty && head_we;
  assign r_ready_o = !fifo_empty && !head_we;
  assign b_hs      = b_valid_i && b_ready_o;
  assign r_hs      = r_valid_i && r_ready_o;
  assign pop       = b_hs || r_hs;
  assign pop_resp  = head_we ? b_resp_i : r_resp_i;

  assign r_ext   = 64'(r_data_i);
  assign rd_lane = (IS64 && head_a2) ? r_ext[63:32] : r_ext[31:0];

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;
  assign aw_addr_o     = addr_q;
  assign ar_addr_o     = addr_q;
  assign aw_valid_o    = aw_pend_q;
  assign w_valid_o     = w_pend_q;
  assign ar_valid_o    = ar_pend_q;

  generate
    if (AXI_DATA_WIDTH == 64) begin : g_w64
      assign w_data_o = {wdata_q, wdata_q};
      assign w_strb_o = addr_q[2] ? {be_q, 4'b0000} : {4'b0000, be_q};
    end else begin : g_w32
      assign w_data_o = wdata_q;
      assign w_strb_o = be_q;
    end
  endgenerate

  // Slot frees only from registered pendings, so a grant can never overlap an open AW/W/AR.
  always_comb begin
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aw_pend_d = aw_pend_q && !aw_ready_i;
    w_pend_d  = w_pend_q && !w_ready_i;
    ar_pend_d = ar_pend_q && !ar_ready_i;
    if (gnt) begin
      addr_d    = data_addr_i;
      be_d      = data_be_i;
      wdata_d   = data_wdata_i;
      aw_pend_d = data_we_i;
      w_pend_d  = data_we_i;
      ar_pend_d = !data_we_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (gnt) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({gnt, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    rvalid_d = pop;
    err_d    = pop && (pop_resp != 2'b00);
    rdata_d  = rdata_q;
    if (r_hs) begin
      rdata_d = rd_lane;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ar_pend_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      ar_pend_q <= ar_pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Entry contents need no reset: they are only read while the counter says valid.
  always_ff @(posedge clk_i) begin
    if (gnt) begin
      fifo_we_q[wr_ptr_q] <= data_we_i;
      fifo_a2_q[wr_ptr_q] <= data_addr_i[2];
    end
  end

endmodule
